overflow_split_accumulator: RTL and testbench

- Multi-lane streaming accumulator that sums signed products per lane over a burst, then splits each lane total into MSP/LSP at a parametrised split point.
- Sits between the MAC array and the cascade chain. Generalises the earlier combinational splitter with lane count, split point, handshakes, overflow tracking and an output holding stage.

---
 rtl/overflow_split_accumulator_pkg.sv | 38 +++
 rtl/oau_lane_acc.sv | 53 +++++
 rtl/overflow_split_accumulator.sv | 108 ++++++++++
 tb/tb_overflow_split_accumulator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/overflow_split_accumulator_pkg.sv
// rtl/overflow_split_accumulator_pkg.sv - shared state type, lane offsets and overflow-aware adder
package overflow_split_accumulator_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             ovf;
  } add_res_t;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Operands arrive sign-extended to MAX_W, so the wide sum is exact; overflow
  // is judged against the signed range of the w-bit accumulator.
  function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int w, input logic sat);
    logic signed [MAX_W-1:0] s;
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    add_res_t r;
    one = MAX_W'(1);
    s = a + b;
    hi = (one <<< (w - 1)) - one;
    lo = -(one <<< (w - 1));
    r.ovf = (s > hi) || (s < lo);
    if (sat && (s > hi)) r.sum = hi;
    else if (sat && (s < lo)) r.sum = lo;
    else r.sum = s;
    return r;
  endfunction

endpackage

// File: rtl/oau_lane_acc.sv
// rtl/oau_lane_acc.sv - single-lane signed accumulator with sticky overflow
// OAU_SATURATE_EN selects clamping instead of two's-complement wrap.
module oau_lane_acc
  import overflow_split_accumulator_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int ACCUM_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   add_en,
  input  logic                   clr,
  input  logic [IN_WIDTH-1:0]    data,
  output logic [ACCUM_WIDTH-1:0] acc_nxt,
  output logic                   ovf_nxt
);

  logic [ACCUM_WIDTH-1:0] acc;
  logic                   ovf;
  logic                   sat;
  add_res_t               r;
  logic                   unused_sum;

`ifdef OAU_SATURATE_EN
  assign sat = 1'b1;
`else
  assign sat = 1'b0;
`endif

  assign unused_sum = ^r.sum[MAX_W-1:ACCUM_WIDTH];

  // A clamped lane stays pinned until the burst closes.
  always_comb begin
    r       = sat_add(MAX_W'(signed'(acc)), MAX_W'(signed'(data)), ACCUM_WIDTH, sat);
    acc_nxt = acc;
    ovf_nxt = ovf;
    if (add_en && !(sat && ovf)) begin
      acc_nxt = r.sum[ACCUM_WIDTH-1:0];
      ovf_nxt = ovf | r.ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: rtl/overflow_split_accumulator.sv
// rtl/overflow_split_accumulator.sv - multi-lane burst accumulator with MSP/LSP split output
// OAU_SATURATE_EN makes lanes clamp on overflow instead of wrapping.
module overflow_split_accumulator
  import overflow_split_accumulator_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int IN_WIDTH    = 16,
  parameter int ACCUM_WIDTH = 32,
  parameter int SPLIT_POINT = ACCUM_WIDTH / 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_WIDTH-1:0]    in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*ACCUM_WIDTH-1:0] out_msp,
  output logic [LANES*ACCUM_WIDTH-1:0] out_lsp,
  output logic [LANES-1:0]             out_ovf,
  output logic [CNT_WIDTH-1:0]         out_beats
);

  state_t                       state;
  state_t                       state_nxt;
  logic                         xfer;
  logic                         last_xfer;
  logic                         slot_free;
  logic                         load_out;
  logic [LANES*ACCUM_WIDTH-1:0] acc_nxt;
  logic [LANES*ACCUM_WIDTH-1:0] out_acc;
  logic [LANES-1:0]             ovf_nxt;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [CNT_WIDTH-1:0]         cnt_nxt;

  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && in_last;
  assign slot_free = !out_valid || out_ready;
  // The output register takes a total either straight from a closing beat or from the held lanes.
  assign load_out  = (last_xfer && slot_free) || ((state == HOLD) && out_ready);

  assign cnt_nxt = (xfer && (cnt != {CNT_WIDTH{1'b1}})) ? cnt + CNT_WIDTH'(1) : cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_xfer && !slot_free) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst || load_out) cnt <= '0;
    else                 cnt <= cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= '0;
      out_beats <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_acc   <= acc_nxt;
      out_ovf   <= ovf_nxt;
      out_beats <= cnt_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int IO = lane_lo(i, IN_WIDTH);
    localparam int AO = lane_lo(i, ACCUM_WIDTH);

    oau_lane_acc #(
      .IN_WIDTH   (IN_WIDTH),
      .ACCUM_WIDTH(ACCUM_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .add_en (xfer),
      .clr    (load_out),
      .data   (in_data[IO +: IN_WIDTH]),
      .acc_nxt(acc_nxt[AO +: ACCUM_WIDTH]),
      .ovf_nxt(ovf_nxt[i])
    );

    assign out_msp[AO +: ACCUM_WIDTH] =
      {{SPLIT_POINT{1'b0}}, out_acc[AO + SPLIT_POINT +: ACCUM_WIDTH - SPLIT_POINT]};
    assign out_lsp[AO +: ACCUM_WIDTH] =
      {{(ACCUM_WIDTH - SPLIT_POINT){1'b0}}, out_acc[AO +: SPLIT_POINT]};
  end

endmodule

// File: tb/tb_overflow_split_accumulator.sv
// tb/tb_overflow_split_accumulator.sv - directed table, long overflow burst and randomized model check
module tb_overflow_split_accumulator;

  localparam int LANES = 4;
  localparam int IN_WIDTH = 16;
  localparam int ACCUM_WIDTH = 32;
  localparam int SPLIT_POINT = 16;
  localparam int CNT_WIDTH = 8;
`ifdef OAU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;
  localparam longint MODV = 64'sd4294967296;
  localparam logic [127:0] Z = '0;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_msp;
  logic [127:0] out_lsp;
  logic [3:0]   out_ovf;
  logic [7:0]   out_beats;

  int total;
  int bad;

  overflow_split_accumulator #(
    .LANES(LANES), .IN_WIDTH(IN_WIDTH), .ACCUM_WIDTH(ACCUM_WIDTH),
    .SPLIT_POINT(SPLIT_POINT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_msp(out_msp), .out_lsp(out_lsp),
    .out_ovf(out_ovf), .out_beats(out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: running lane sums, one result slot, one held burst.
  longint   m_acc[4];
  bit [3:0] m_ovf;
  int       m_cnt;
  bit       m_held;
  bit       m_slot_v;
  longint   m_slot[4];
  bit [3:0] m_slot_ovf;
  int       m_slot_beats;

  function automatic void m_clear_partial();
    for (int l = 0; l < 4; l++) m_acc[l] = 0;
    m_ovf = '0;
    m_cnt = 0;
  endfunction

  function automatic void m_publish();
    for (int l = 0; l < 4; l++) m_slot[l] = (m_acc[l] < 0) ? m_acc[l] + MODV : m_acc[l];
    m_slot_ovf = m_ovf;
    m_slot_beats = m_cnt;
    m_slot_v = 1'b1;
    m_clear_partial();
  endfunction

  function automatic void m_beat(input logic [63:0] d);
    logic signed [15:0] t;
    longint s;
    for (int l = 0; l < 4; l++) begin
      t = d[l*16 +: 16];
      if (!(SAT && m_ovf[l])) begin
        s = m_acc[l] + longint'(t);
        if (s > AMAX) begin
          m_ovf[l] = 1'b1;
          s = SAT ? AMAX : s - MODV;
        end else if (s < AMIN) begin
          m_ovf[l] = 1'b1;
          s = SAT ? AMIN : s + MODV;
        end
        m_acc[l] = s;
      end
    end
    if (m_cnt < 255) m_cnt++;
  endfunction

  function automatic void model_step(input bit r, input bit v, input bit l,
                                     input logic [63:0] d, input bit o);
    if (r) begin
      m_clear_partial();
      m_held = 1'b0;
      m_slot_v = 1'b0;
      for (int k = 0; k < 4; k++) m_slot[k] = 0;
      m_slot_ovf = '0;
      m_slot_beats = 0;
    end else if (m_held) begin
      if (o) begin
        m_publish();
        m_held = 1'b0;
      end
    end else begin
      if (v) m_beat(d);
      if (v && l) begin
        if (!m_slot_v || o) m_publish();
        else m_held = 1'b1;
      end else if (o) begin
        m_slot_v = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [127:0] em;
    logic [127:0] el;
    for (int l = 0; l < 4; l++) begin
      em[l*32 +: 32] = 32'(m_slot[l] >> 16);
      el[l*32 +: 32] = 32'(m_slot[l] % 65536);
    end
    chk("model.in_ready", 128'(in_ready), 128'(!m_held));
    chk("model.out_valid", 128'(out_valid), 128'(m_slot_v));
    chk("model.out_msp", out_msp, em);
    chk("model.out_lsp", out_lsp, el);
    chk("model.out_ovf", 128'(out_ovf), 128'(m_slot_ovf));
    chk("model.out_beats", 128'(out_beats), 128'(m_slot_beats));
  endtask

  task automatic cycle(input bit r, input bit v, input bit l, input logic [63:0] d,
                       input bit o, input bit do_chk);
    rst = r;
    in_valid = v;
    in_last = l;
    in_data = d;
    out_ready = o;
    model_step(r, v, l, d, o);
    @(posedge clk);
    #1;
    if (do_chk) compare_model();
  endtask

  typedef struct {
    bit           r;
    bit           v;
    bit           l;
    logic [63:0]  d;
    bit           o;
    bit           e_rdy;
    bit           e_val;
    logic [127:0] e_msp;
    logic [127:0] e_lsp;
    logic [7:0]   e_beats;
    logic [3:0]   e_ovf;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit v, input bit l, input logic [63:0] d,
                              input bit o, input bit er, input bit ev, input logic [127:0] em,
                              input logic [127:0] el, input logic [7:0] eb, input logic [3:0] eo);
    vec_t x;
    x.r = r; x.v = v; x.l = l; x.d = d; x.o = o;
    x.e_rdy = er; x.e_val = ev; x.e_msp = em; x.e_lsp = el; x.e_beats = eb; x.e_ovf = eo;
    return x;
  endfunction

  function automatic logic [127:0] ln0(input logic [31:0] x);
    return {96'h0, x};
  endfunction

  vec_t tbl[17];

  initial begin
    logic [127:0] m3;
    logic [127:0] l3;
    logic [127:0] m8;
    logic [127:0] l8;
    logic [31:0]  e2;
    logic [31:0]  e3;
    total = 0;
    bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;

    m3 = {32'h0, 32'h0, 32'h0000_ffff, 32'h0};
    l3 = ln0(32'h0000_82ff);
    m8 = {32'h0000_ffff, 96'h0};
    l8 = {32'h0000_ffff, 64'h0, 32'h1};
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, Z, Z, 8'd0, 4'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_0100, 1'b1, 1'b1, 1'b0, Z, Z, 8'd0, 4'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_0200, 1'b1, 1'b1, 1'b0, Z, Z, 8'd0, 4'd0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_7fff, 1'b1, 1'b1, 1'b1, m3, l3, 8'd3, 4'd0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 64'h5, 1'b0, 1'b0, 1'b1, m3, l3, 8'd3, 4'd0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 64'h9, 1'b0, 1'b0, 1'b1, m3, l3, 8'd3, 4'd0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, Z, ln0(32'h5), 8'd1, 4'd0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 64'h7, 1'b1, 1'b1, 1'b1, Z, ln0(32'h7), 8'd1, 4'd0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 64'hffff_0000_0000_0001, 1'b1, 1'b1, 1'b1, m8, l8, 8'd1, 4'd0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0, m8, l8, 8'd1, 4'd0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 64'h3, 1'b1, 1'b1, 1'b0, m8, l8, 8'd1, 4'd0);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 64'h3, 1'b1, 1'b1, 1'b0, Z, Z, 8'd0, 4'd0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 64'h2, 1'b0, 1'b1, 1'b1, Z, ln0(32'h2), 8'd1, 4'd0);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 64'h4, 1'b0, 1'b0, 1'b1, Z, ln0(32'h2), 8'd1, 4'd0);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, Z, Z, 8'd0, 4'd0);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 64'h5, 1'b1, 1'b1, 1'b1, Z, ln0(32'h5), 8'd1, 4'd0);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, Z, ln0(32'h5), 8'd1, 4'd0);

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].o, 1'b1);
      chk($sformatf("row%0d.in_ready", i), 128'(in_ready), 128'(tbl[i].e_rdy));
      chk($sformatf("row%0d.out_valid", i), 128'(out_valid), 128'(tbl[i].e_val));
      chk($sformatf("row%0d.out_msp", i), out_msp, tbl[i].e_msp);
      chk($sformatf("row%0d.out_lsp", i), out_lsp, tbl[i].e_lsp);
      chk($sformatf("row%0d.out_beats", i), 128'(out_beats), 128'(tbl[i].e_beats));
      chk($sformatf("row%0d.out_ovf", i), 128'(out_ovf), 128'(tbl[i].e_ovf));
    end

    // Lane 2 overflows positively and lane 3 negatively; the beat count saturates.
    for (int i = 0; i < 65540; i++)
      cycle(1'b0, 1'b1, i == 65539, {16'h8000, 16'h7fff, 32'h0}, 1'b1,
            (i % 4096 == 0) || (i > 65530));
    e2 = SAT ? 32'h7fff_ffff : 32'h8000_fffc;
    e3 = SAT ? 32'h8000_0000 : 32'h7ffe_0000;
    chk("long.out_valid", 128'(out_valid), 128'(1'b1));
    chk("long.out_beats", 128'(out_beats), 128'(8'd255));
    chk("long.out_ovf", 128'(out_ovf), 128'(4'b1100));
    chk("long.lane2_msp", 128'(out_msp[64 +: 32]), 128'({16'h0, e2[31:16]}));
    chk("long.lane2_lsp", 128'(out_lsp[64 +: 32]), 128'({16'h0, e2[15:0]}));
    chk("long.lane3_msp", 128'(out_msp[96 +: 32]), 128'({16'h0, e3[31:16]}));
    chk("long.lane3_lsp", 128'(out_lsp[96 +: 32]), 128'({16'h0, e3[15:0]}));
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);

    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            {$urandom, $urandom}, $urandom_range(0, 9) < 6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
